// File: rtl/skinny_2shares_loader_if.sv
// Bundles the UART byte streams, the 2-share core handshake and the loader status flags.
// slave is the loader's view; master is the view of whatever drives and observes it.
interface skinny_2shares_loader_if;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [255:0]  core_input_o;
  logic [255:0]  core_key_o;
  logic [127:0]  core_tweak1_o;
  logic [127:0]  core_tweak2_o;
  logic [1215:0] core_random_o;
  logic          core_start_o;
  logic          core_done_i;
  logic [255:0]  core_cipher_i;
  logic          busy_o;
  logic          error_o;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i, core_done_i, core_cipher_i,
    output tx_data_o, tx_valid_o, core_input_o, core_key_o, core_tweak1_o, core_tweak2_o,
    output core_random_o, core_start_o, busy_o, error_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i, core_done_i, core_cipher_i,
    input  tx_data_o, tx_valid_o, core_input_o, core_key_o, core_tweak1_o, core_tweak2_o,
    input  core_random_o, core_start_o, busy_o, error_o
  );
endinterface

// File: rtl/skinny_2shares_loader.sv
// UART frame loader and result streamer for a 2-share SKINNY core.
// Define SKINNY_LOADER_UNMASK_EN to recombine the shares and send 16 bytes instead of 32.
module skinny_2shares_loader #(
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input logic                     clk_i,
  input logic                     rst_i,
  skinny_2shares_loader_if.slave  bus
);

  localparam int unsigned FrameW = 1984;
  localparam logic [7:0]  LastByte = 8'd247;
`ifdef SKINNY_LOADER_UNMASK_EN
  localparam int unsigned TxBytes = 16;
`else
  localparam int unsigned TxBytes = 32;
`endif
  localparam int unsigned TxW    = 8 * TxBytes;
  localparam int unsigned TimerW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StSend
  } state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [TxW-1:0]      tx_q, tx_d;
  logic [4:0]          tx_idx_q, tx_idx_d;
  logic                error_q, error_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StLoad;
      frame_q    <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      tx_q       <= '0;
      tx_idx_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      tx_q       <= tx_d;
      tx_idx_q   <= tx_idx_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    tx_d       = tx_q;
    tx_idx_d   = tx_idx_q;
    error_d    = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (bus.rx_valid_i) begin
          frame_d = {frame_q[FrameW-9:0], bus.rx_data_i};
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d = '0;
            state_d    = StStart;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!bus.core_done_i) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerW'(DONE_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StLoad;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (bus.core_done_i) begin
`ifdef SKINNY_LOADER_UNMASK_EN
          tx_d = bus.core_cipher_i[255:128] ^ bus.core_cipher_i[127:0];
`else
          tx_d = bus.core_cipher_i;
`endif
          tx_idx_d = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (bus.tx_ready_i) begin
          // The TX register shifts so the outgoing byte always sits in the MSB position.
          tx_d = tx_q << 8;
          if (tx_idx_q == 5'(TxBytes - 1)) begin
            state_d = StLoad;
          end else begin
            tx_idx_d = tx_idx_q + 5'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign bus.tx_data_o     = tx_q[TxW-1 -: 8];
  assign bus.tx_valid_o    = (state_q == StSend);
  assign bus.core_start_o  = (state_q == StStart);
  assign bus.busy_o        = (state_q != StLoad);
  assign bus.error_o       = error_q;

  // First received byte ends up in the MSB byte of core_input_o.
  assign bus.core_input_o  = frame_q[1983:1728];
  assign bus.core_key_o    = frame_q[1727:1472];
  assign bus.core_tweak1_o = frame_q[1471:1344];
  assign bus.core_tweak2_o = frame_q[1343:1216];
  assign bus.core_random_o = frame_q[1215:0];

endmodule

// File: tb/tb_skinny_2shares_loader.sv
// Self-checking bench for skinny_2shares_loader: frame loading, core handshake, TX streaming,
// timeout, reset and dropped-byte behaviour, with a queue of expected TX bytes.
module tb_skinny_2shares_loader;

  localparam int unsigned DoneTimeout = 255;
`ifdef SKINNY_LOADER_UNMASK_EN
  localparam int TxBytes = 16;
`else
  localparam int TxBytes = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skinny_2shares_loader_if bus ();

  skinny_2shares_loader #(
    .DONE_TIMEOUT(DoneTimeout)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]    exp_q[$];
  logic [1983:0] exp_frame = '0;
  int            cyc = 0;
  int            n_start = 0, n_err = 0, n_tx = 0;
  int            start_cyc = 0, err_cyc = 0;
  logic          model_en = 1'b1;
  logic          ready_mode = 1'b0;
  logic [3:0]    ready_pat = 4'b1001;
  int            rcnt = 0;
  int            dcnt = 0;
  logic          stall = 1'b0;
  logic [7:0]    held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model core: done falls after start and rises 40 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_done_i <= 1'b1;
      dcnt <= 0;
    end else if (model_en && bus.core_start_o) begin
      bus.core_done_i <= 1'b0;
      dcnt <= 40;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) bus.core_done_i <= 1'b1;
    end
  end

  always @(posedge clk) begin
    rcnt <= rcnt + 1;
    bus.tx_ready_i <= ready_mode ? ready_pat[rcnt % 4] : 1'b1;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (bus.core_start_o) begin n_start++; start_cyc = cyc; end
      if (bus.error_o) begin n_err++; err_cyc = cyc; end
      if (bus.tx_valid_o) begin
        if (stall) check("tx_hold", bus.tx_data_o, held);
        if (bus.tx_ready_i) begin
          e = 'x;
          if (exp_q.size() != 0) e = exp_q.pop_front();
          check("tx_byte", bus.tx_data_o, e);
          stall = 1'b0;
          n_tx++;
        end else begin
          stall = 1'b1;
          held  = bus.tx_data_o;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int mult, input int seed, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i * mult + seed);
      exp_frame[1983 - 8 * i -: 8] = b;
      send_byte(b);
    end
  endtask

  task automatic push_tx(input logic [255:0] c);
    for (int k = 0; k < TxBytes; k++) begin
`ifdef SKINNY_LOADER_UNMASK_EN
      exp_q.push_back(c[255 - 8 * k -: 8] ^ c[127 - 8 * k -: 8]);
`else
      exp_q.push_back(c[255 - 8 * k -: 8]);
`endif
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_input"}, bus.core_input_o, exp_frame[1983:1728]);
    check({tag, "_key"}, bus.core_key_o, exp_frame[1727:1472]);
    check({tag, "_tweak1"}, bus.core_tweak1_o, exp_frame[1471:1344]);
    check({tag, "_tweak2"}, bus.core_tweak2_o, exp_frame[1343:1216]);
    check({tag, "_rand_hi"}, bus.core_random_o[1215:960], exp_frame[1215:960]);
    check({tag, "_rand_lo"}, bus.core_random_o[255:0], exp_frame[255:0]);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (bus.busy_o !== lvl && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, bus.busy_o, lvl);
  endtask

  task automatic run_tx(input string tag, input int tx0);
    wait_busy(1'b0, 3000, {tag, "_idle"});
    check({tag, "_txv_low"}, bus.tx_valid_o, 1'b0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_tx_count"}, n_tx - tx0, TxBytes);
  endtask

  logic [255:0] cipher;
  int s0, e0, t0, n;

  initial begin
    rst = 1'b1;
    bus.rx_data_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.core_cipher_i = '0;
    #1;
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_txv", bus.tx_valid_o, 1'b0);
    check("rst_start", bus.core_start_o, 1'b0);
    check("rst_error", bus.error_o, 1'b0);
    check("rst_input", bus.core_input_o, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Counting frame, fixed A5/5A cipher, ready always high.
    cipher = {{16{8'hA5}}, {16{8'h5A}}};
    bus.core_cipher_i = cipher;
    push_tx(cipher);
    s0 = n_start; t0 = n_tx;
    send_frame(1, 0, 248);
    check("t1_busy", bus.busy_o, 1'b1);
    check_frame("t1");
    check("t1_input_msb", bus.core_input_o[255:248], 8'h00);
    check("t1_key_msb", bus.core_key_o[255:248], 8'h20);
    check("t1_rand_lsb", bus.core_random_o[7:0], 8'hF7);
    run_tx("t1", t0);
    check("t1_starts", n_start - s0, 1);

    // Stalling receiver plus bytes arriving while the core runs.
    ready_mode = 1'b1;
    cipher = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.core_cipher_i = cipher;
    push_tx(cipher);
    t0 = n_tx;
    send_frame(7, 3, 248);
    check("t2_busy", bus.busy_o, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    check_frame("t2_extra");
    run_tx("t2", t0);

    // Core never drops done: timeout, then a fresh frame.
    ready_mode = 1'b0;
    model_en = 1'b0;
    s0 = n_start; e0 = n_err;
    send_frame(3, 1, 248);
    wait_busy(1'b0, DoneTimeout + 20, "t3_timeout");
    repeat (2) @(posedge clk);
    #1;
    check("t3_err_pulses", n_err - e0, 1);
    check("t3_err_cycle", err_cyc - start_cyc, DoneTimeout + 1);
    check("t3_txv", bus.tx_valid_o, 1'b0);
    model_en = 1'b1;
    cipher = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.core_cipher_i = cipher;
    push_tx(cipher);
    t0 = n_tx;
    send_frame(5, 17, 248);
    check_frame("t3_fresh");
    run_tx("t3", t0);

    // Reset during SEND, then during a partial frame.
    ready_mode = 1'b1;
    push_tx(cipher);
    send_frame(1, 100, 248);
    n = 0;
    while (bus.tx_valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_reached_send", bus.tx_valid_o, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_txv", bus.tx_valid_o, 1'b0);
    check("t4_rst_busy", bus.busy_o, 1'b0);
    check("t4_rst_input", bus.core_input_o, '0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    send_frame(1, 50, 100);
    #1 rst = 1'b1;
    #1;
    check("t4_rst2_input", bus.core_input_o, '0);
    check("t4_rst2_start", bus.core_start_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cipher = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.core_cipher_i = cipher;
    push_tx(cipher);
    t0 = n_tx;
    send_frame(11, 7, 248);
    check("t4_busy", bus.busy_o, 1'b1);
    check_frame("t4");
    run_tx("t4", t0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/skinny_2shares_loader.md
SKINNY_2SHARES_LOADER -- requirements
Module: skinny_2shares_loader

Interface
REQ-001 The block SHALL have parameter DONE_TIMEOUT, default 255, meaning the maximum number of cycles WAIT_BUSY waits for core_done_i to fall.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port rx_data_i, input, 8 bits: received UART byte.
REQ-005 The block SHALL have port rx_valid_i, input, 1 bit: one-cycle strobe qualifying rx_data_i; there is no backpressure.
REQ-006 The block SHALL have port tx_data_o, output, 8 bits: byte to the UART transmitter.
REQ-007 The block SHALL have port tx_valid_o, output, 1 bit: tx_data_o is valid.
REQ-008 The block SHALL have port tx_ready_i, input, 1 bit: the transmitter accepts a byte.
REQ-009 The block SHALL have ports core_input_o and core_key_o, output, 256 bits each: the masked plaintext and key shares.
REQ-010 The block SHALL have ports core_tweak1_o and core_tweak2_o, output, 128 bits each: the tweak words.
REQ-011 The block SHALL have port core_random_o, output, 1216 bits: the mask randomness seed.
REQ-012 The block SHALL have port core_start_o, output, 1 bit: one-cycle start pulse to the 2-share core.
REQ-013 The block SHALL have port core_done_i, input, 1 bit: core done flag; it is high when idle, falls the cycle after start, and rises on completion.
REQ-014 The block SHALL have port core_cipher_i, input, 256 bits: the core's shared ciphertext; bits 255:128 are share 1 and bits 127:0 are share 0.
REQ-015 The block SHALL have ports busy_o and error_o, output, 1 bit each: busy_o is high whenever the FSM is not in LOAD; error_o is a one-cycle timeout pulse.

Function
REQ-016 The FSM SHALL have the states LOAD, START, WAIT_BUSY, WAIT_DONE and SEND.
REQ-017 The block SHALL hold a 1984-bit frame register; in LOAD, each rx_valid_i shifts it left 8 bits with rx_data_i entering bits 7:0, and increments an 8-bit byte counter.
REQ-018 The frame mapping SHALL be: [1983:1728] to core_input_o, [1727:1472] to core_key_o, [1471:1344] to core_tweak1_o, [1343:1216] to core_tweak2_o, [1215:0] to core_random_o; the first byte of the frame lands in the MSB byte.
REQ-019 When the counter reaches 247 and a byte is accepted, the counter SHALL clear and the FSM SHALL go to START.
REQ-020 Bytes that arrive while the FSM is outside LOAD SHALL be dropped, and the frame register SHALL NOT change.
REQ-021 START SHALL assert core_start_o for exactly one cycle and then go to WAIT_BUSY; core_* data outputs SHALL remain stable from START until the FSM returns to LOAD.
REQ-022 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle core_done_i=0.
REQ-023 If core_done_i is still 1 after DONE_TIMEOUT cycles in WAIT_BUSY, the block SHALL pulse error_o for one cycle and return to LOAD.
REQ-024 WAIT_DONE SHALL wait with no timeout; on core_done_i=1 it SHALL capture core_cipher_i into a TX register, clear the TX index and go to SEND.
REQ-025 In SEND, tx_valid_o SHALL be 1 and tx_data_o SHALL be the TX register byte selected by the index, MSB byte first.
REQ-026 A byte SHALL transfer only when tx_valid_o and tx_ready_i are both 1; tx_data_o SHALL be held stable while tx_ready_i=0.
REQ-027 After the last byte transfers, the FSM SHALL return to LOAD with tx_valid_o=0 on the next cycle.
REQ-028 A core_done_i glitch high while in WAIT_BUSY SHALL be ignored.

Reset
REQ-029 Asserting rst_i at any time, including mid-frame or mid-SEND, SHALL immediately put the FSM in LOAD, clear the byte counter, TX index and frame register, and drive tx_valid_o, core_start_o, error_o and busy_o to 0.
REQ-030 After rst_i deasserts, the first accepted byte SHALL be treated as frame byte 0.

Configuration
REQ-031 With SKINNY_LOADER_UNMASK_EN defined, the capture SHALL store core_cipher_i[255:128]^core_cipher_i[127:0] and SEND SHALL transmit 16 unmasked bytes.
REQ-032 Without SKINNY_LOADER_UNMASK_EN, SEND SHALL transmit 32 bytes: share 1 bytes 255:248 down to 135:128, then share 0 bytes 127:120 down to 7:0.

Verification
REQ-033 Feed 248 bytes with values 0x00,0x01,...,0xF7 -> core_input_o[255:248]=0x00, core_key_o[255:248]=0x20, core_random_o[7:0]=0xF7, and exactly one core_start_o pulse.
REQ-034 Run a model core that drops done 1 cycle after start and raises it 40 cycles later with cipher=all 0xA5 in share 1 and all 0x5A in share 0 -> unmask build sends 16 bytes of 0xFF; share build sends 16 bytes of 0xA5 then 16 bytes of 0x5A.
REQ-035 Toggle tx_ready_i as 1,0,0,1 repeatedly -> no byte lost or duplicated, and tx_data_o is stable during every stall.
REQ-036 Hold core_done_i at 1 after start -> error_o pulses at cycle DONE_TIMEOUT+1 and the next 248 bytes form a fresh frame.
REQ-037 Assert rst_i after 100 bytes, then send a full frame -> the outputs match the new frame only.
REQ-038 Send 5 extra bytes during WAIT_DONE -> the extra bytes are ignored and the frame outputs are unchanged.
